// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - truth-table sweep controller for a small combinational gate
// Optional feature: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_sweep_ctrl #(
   parameter int                      N_IN   = 3,
   parameter logic [(1<<N_IN)-1:0]    EXPECT = 8'b0111_1111,
   parameter int                      SETTLE = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    dut_y,
   output logic [N_IN-1:0]         dut_in,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic [N_IN:0]           err_cnt,
   output logic [(1<<N_IN)-1:0]    fail_vec,
   output logic [N_IN-1:0]         first_fail
);

   localparam int              NV       = 1 << N_IN;
   localparam logic [N_IN-1:0] LAST     = N_IN'(NV - 1);
   localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

   typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_t;

   state_t     state, state_n;
   logic [3:0] cnt;
   logic       mismatch;
   logic       launch;
   logic       advance;
   logic       record;

   // Next-state and datapath strobes; dut_in doubles as the vector index
   always_comb begin
      state_n  = state;
      launch   = 1'b0;
      advance  = 1'b0;
      record   = 1'b0;
      mismatch = (dut_y != EXPECT[dut_in]);
      case (state)
         IDLE, DONE: begin
            if (start) begin
               launch  = 1'b1;
               state_n = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_n = CHECK;
         end
         CHECK: begin
            record = mismatch;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
            if (mismatch || dut_in == LAST) begin
               state_n = DONE;
            end else begin
               advance = 1'b1;
               state_n = WAIT;
            end
`else
            if (dut_in == LAST) begin
               state_n = DONE;
            end else begin
               advance = 1'b1;
               state_n = WAIT;
            end
`endif
         end
         default: state_n = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   // Vector index, settle counter and result accumulation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dut_in     <= '0;
         cnt        <= 4'd0;
         err_cnt    <= '0;
         fail_vec   <= '0;
         first_fail <= '0;
      end else begin
         if (launch) begin
            dut_in     <= '0;
            cnt        <= SETTLE_C;
            err_cnt    <= '0;
            fail_vec   <= '0;
            first_fail <= '0;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (record) begin
            fail_vec[dut_in] <= 1'b1;
            err_cnt          <= err_cnt + 1'b1;
            // err_cnt still zero means this is the first mismatch of the sweep
            if (err_cnt == '0) first_fail <= dut_in;
         end
         if (advance) begin
            dut_in <= dut_in + 1'b1;
            cnt    <= SETTLE_C;
         end
      end
   end

   assign busy = (state == WAIT) || (state == CHECK);
   assign done = (state == DONE);
   assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl
module tb_gate_sweep_ctrl;

   localparam logic [7:0] NAND_TT = 8'h7F;
   localparam logic [7:0] AND_TT  = 8'h80;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       start0 = 1'b0, start3 = 1'b0;
   logic [7:0] tt0 = NAND_TT, tt3 = NAND_TT;
   logic       dly_en0 = 1'b0, dly_en3 = 1'b0;
   logic       y0, y3;

   logic [2:0] dut_in0, ff0, dut_in3, ff3;
   logic       busy0, done0, pass0, busy3, done3, pass3;
   logic [3:0] err0, err3;
   logic [7:0] fv0, fv3;

   logic [2:0] dl0 [3];
   logic [2:0] dl3 [3];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gate_sweep_ctrl #(.N_IN(3), .EXPECT(8'b0111_1111), .SETTLE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .dut_y(y0), .dut_in(dut_in0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
      .fail_vec(fv0), .first_fail(ff0)
   );

   gate_sweep_ctrl #(.N_IN(3), .EXPECT(8'b0111_1111), .SETTLE(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .dut_y(y3), .dut_in(dut_in3),
      .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
      .fail_vec(fv3), .first_fail(ff3)
   );

   // Gate models: truth table lookup, optionally seeing the inputs 3 cycles late
   always @(posedge clk) begin
      dl0[0] <= dut_in0; dl0[1] <= dl0[0]; dl0[2] <= dl0[1];
      dl3[0] <= dut_in3; dl3[1] <= dl3[0]; dl3[2] <= dl3[1];
   end
   assign y0 = dly_en0 ? tt0[dl0[2]] : tt0[dut_in0];
   assign y3 = dly_en3 ? tt3[dl3[2]] : tt3[dut_in3];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: mismatches are simply the XOR of observed and expected tables
   task automatic model(input logic [7:0] tt, input int s, output logic [7:0] fv,
                        output int err, output int ff, output int dc);
      logic [7:0] m;
      m   = tt ^ 8'b0111_1111;
      fv  = 8'h00;
      err = 0;
      ff  = 0;
      dc  = 8 * (s + 2);
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
            if (err == 0) begin
               ff    = i;
               fv[i] = 1'b1;
               err   = 1;
               dc    = (i + 1) * (s + 2);
            end
`else
            if (err == 0) ff = i;
            fv[i] = 1'b1;
            err++;
`endif
         end
      end
   endtask

   // Pulse (or hold) start on one instance and count edges until done
   task automatic sweep(input int which, input logic hold, output int n);
      int s;
      s = (which == 3) ? 3 : 0;
      @(negedge clk);
      if (which == 3) start3 = 1'b1; else start0 = 1'b1;
      @(negedge clk);
      if (!hold) begin
         start0 = 1'b0;
         start3 = 1'b0;
      end
      n = 0;
      while (((which == 3) ? done3 : done0) == 1'b0 && n < 300) begin
         check("busy_in_sweep", (which == 3) ? busy3 : busy0, 1'b1);
         check("dut_in_step", (which == 3) ? dut_in3 : dut_in0, 32'(n / (s + 2)));
         @(negedge clk);
         n++;
      end
      check("done_in_budget", n < 300, 1'b1);
      check("busy_low_at_done", (which == 3) ? busy3 : busy0, 1'b0);
   endtask

   task automatic verify(input int which, input logic [7:0] tt);
      logic [7:0] efv;
      int eerr, eff, edc, n;
      model(tt, (which == 3) ? 3 : 0, efv, eerr, eff, edc);
      if (which == 3) tt3 = tt; else tt0 = tt;
      sweep(which, 1'b0, n);
      check("done_cycle", n, edc);
      check("fail_vec", (which == 3) ? fv3 : fv0, efv);
      check("err_cnt", (which == 3) ? err3 : err0, eerr);
      check("first_fail", (which == 3) ? ff3 : ff0, eff);
      check("pass", (which == 3) ? pass3 : pass0, eerr == 0);
   endtask

   initial begin
      logic [7:0] efv;
      int eerr, eff, edc, n;

      #2 rst_n = 1'b0;
      #1;
      check("rst_dut_in", dut_in0, 0);
      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_pass", pass0, 0);
      check("rst_err", err0, 0);
      check("rst_fail_vec", fv0, 0);
      check("rst_first_fail", ff0, 0);
      check("rst_done3", done3, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      verify(0, NAND_TT);
      verify(0, 8'hFF);
      verify(0, AND_TT);

      dly_en3 = 1'b1;
      verify(3, NAND_TT);
      dly_en3 = 1'b0;

      // Slow gate with no settle time: the final vector sees a stale output
      dly_en0 = 1'b1;
      tt0 = NAND_TT;
      sweep(0, 1'b0, n);
      check("slow_gate_no_settle_pass", pass0, 1'b0);
      dly_en0 = 1'b0;

      // Asynchronous reset in the middle of a failing sweep
      tt0 = 8'hFE;
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_dut_in", dut_in0, 0);
      check("mid_rst_busy", busy0, 0);
      check("mid_rst_done", done0, 0);
      check("mid_rst_pass", pass0, 0);
      check("mid_rst_err", err0, 0);
      check("mid_rst_fail_vec", fv0, 0);
      check("mid_rst_first_fail", ff0, 0);
      check("mid_rst_done3", done3, 0);
      @(negedge clk) rst_n = 1'b1;
      verify(0, NAND_TT);

      // start held high: no restart while busy, immediate restart from DONE
      tt0 = AND_TT;
      model(AND_TT, 0, efv, eerr, eff, edc);
      sweep(0, 1'b1, n);
      check("held_done_cycle", n, edc);
      check("held_err", err0, eerr);
      check("held_fail_vec", fv0, efv);
      @(negedge clk);
      start0 = 1'b0;
      check("restart_done_low", done0, 0);
      check("restart_busy", busy0, 1);
      check("restart_err_clr", err0, 0);
      check("restart_fail_vec_clr", fv0, 0);
      check("restart_dut_in", dut_in0, 0);
      n = 0;
      while (!done0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("restart_completes", n < 300, 1'b1);

      // Randomized gate behaviour against the reference
      for (int k = 0; k < 8; k++) verify(0, 8'($urandom));
      for (int k = 0; k < 3; k++) begin
         dly_en3 = 1'($urandom_range(0, 1));
         verify(3, 8'($urandom));
      end
      dly_en3 = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Truth-table sweep controller for small combinational gates under test (e.g. a 3-input NAND). On `start` it drives every input combination onto the gate in ascending binary order and holds each one for a programmable settle time. It samples the gate output, compares it against a parameterised expected truth table, and reports per-vector failures, an error count and pass/fail. It sits between the grading harness and the gate under test, replacing hand-written stimulus sequences.

## Interface
- `N_IN`, default 3: number of gate inputs; `2**N_IN` vectors are swept.
- `EXPECT`, default `8'b0111_1111`: expected output, bit *i* = expected `dut_y` for input vector *i*. Width `2**N_IN`. The default is 3-input NAND.
- `SETTLE`, default 0: extra hold cycles per vector before sampling (0..15).

- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: begin a sweep; accepted only in IDLE or DONE.
- `dut_y` input 1: output of gate under test.
- `dut_in` output N_IN: vector driven to gate inputs; bit N_IN-1 = `a` (MSB), bit 0 = last input (`c`).
- `busy` output 1: sweep in progress.
- `done` output 1: sweep finished; held until next accepted `start` or reset.
- `pass` output 1: `done` and `err_cnt == 0`.
- `err_cnt` output N_IN+1: number of mismatching vectors.
- `fail_vec` output 2**N_IN: bit *i* set if vector *i* mismatched.
- `first_fail` output N_IN: index of first mismatch; 0 if none.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- IDLE/DONE, `start`=1: clear `err_cnt`, `fail_vec`, `first_fail`. Set idx←0, `dut_in`←0, cnt←SETTLE, then go to WAIT.
- WAIT: if cnt==0 go to CHECK, else cnt←cnt-1.
- CHECK: mismatch = `dut_y` != `EXPECT[idx]`.
  - On mismatch: set `fail_vec[idx]` and increment `err_cnt`.
  - On the first mismatch: `first_fail`←idx.
  - If idx == 2**N_IN-1, go to DONE. Otherwise idx←idx+1, `dut_in`←idx+1, cnt←SETTLE, then go to WAIT.
- DONE: `done`=1, `busy`=0. Results hold. `dut_in` holds the last vector.
- `start` in WAIT/CHECK is ignored; there is no restart mid-sweep.
- `err_cnt` width N_IN+1 covers all 2**N_IN vectors failing, so it never saturates or wraps.
- `pass` is combinational from state and `err_cnt`; it is 0 outside DONE.

## Timing
- Reset (asynchronous, any state): state IDLE. `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_vec`=0, `first_fail`=0. Takes effect immediately, mid-sweep included.
- `busy` rises the cycle after `start` is accepted and falls on DONE entry. `busy` and `done` are never both 1.
- Per vector: SETTLE+1 WAIT cycles plus 1 CHECK cycle = SETTLE+2 cycles. `dut_in` is stable for SETTLE+2 rising edges before `dut_y` is sampled, at the CHECK edge.
- Full sweep: `done` rises 2**N_IN·(SETTLE+2) cycles after the accepting edge (16 cycles for the defaults).
- `start` in DONE restarts immediately. `done` falls on that same edge.
- `dut_y` is sampled only in CHECK. It may glitch at any other time.

## Configuration
- `GATE_SWEEP_STOP_ON_FAIL_EN` defined: on the first mismatch in CHECK, record it and go straight to DONE. Then `err_cnt`=1, `fail_vec` has a single bit set, and `done` rises early.
- Not defined: all 2**N_IN vectors are always swept and every mismatch is recorded.

## Test plan
- Ideal NAND model, defaults, `start` pulse → `dut_in` steps 0..7, `done` at cycle 16, `pass`=1, `err_cnt`=0, `fail_vec`=8'h00.
- `dut_y` stuck at 1 → `fail_vec`=8'h80, `err_cnt`=1, `first_fail`=7, `pass`=0.
- AND model in place of NAND, macro off → `fail_vec`=8'hFF, `err_cnt`=8, `first_fail`=0. Macro on → `done` at cycle 2, `err_cnt`=1, `fail_vec`=8'h01.
- SETTLE=3 with a model delaying `dut_y` 3 cycles → `pass`=1, `done` at cycle 40. Same model with SETTLE=0 → `pass`=0.
- `rst_n` low at cycle 7 mid-sweep → all outputs 0 at once. A new `start` after release runs a full clean sweep.
- `start` held high throughout the sweep → no restart while `busy`. Restart on the DONE cycle clears results and `done` falls.
